// File: rtl/product_accumulator.sv
// product_accumulator: sums unsigned multiplier products into a saturating
// dot-product result. The result is emitted after N_TERMS products, or
// earlier when a beat is flagged last. Valid/ready handshakes on both sides.
module product_accumulator #(
  parameter int unsigned parallelism = 8,
  parameter int unsigned ACC_GUARD   = 8,
  parameter int unsigned N_TERMS     = 16   // must be >= 1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         clear,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [2*parallelism-1:0]                     product,
  input  logic                                         in_last,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [2*parallelism+ACC_GUARD-1:0]           out_sum,
  output logic [$clog2(N_TERMS+1)-1:0]                 out_count,
  output logic                                         out_ovf
);

  localparam int unsigned PROD_W = 2 * parallelism;
  localparam int unsigned ACC_W  = PROD_W + ACC_GUARD;
  localparam int unsigned CNT_W  = $clog2(N_TERMS + 1);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;

  // Datapath helpers for the beat being accepted this cycle.
  logic               accept;
  logic [ACC_W:0]     sum_wide;
  logic [ACC_W-1:0]   acc_nx;
  logic [CNT_W-1:0]   cnt_nx;
  logic               ovf_nx;
  logic               close_nx;

  // Ready is purely a function of state and clear, never of in_valid.
  assign in_ready = (state_q == ST_ACC) && !clear;
  assign accept   = in_valid && in_ready;

  // Saturating add of the zero-extended product, plus term counting.
  always_comb begin
    sum_wide = {1'b0, acc_q} + (ACC_W + 1)'(product);
    ovf_nx   = sum_wide[ACC_W] | ovf_q;
    acc_nx   = ovf_nx ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    cnt_nx   = cnt_q + CNT_W'(1);
    close_nx = (cnt_nx == CNT_W'(N_TERMS)) || in_last;
  end

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    unique case (state_q)
      ST_ACC: begin
        if (clear) begin
          // Discard the partial sum; no beat is taken this cycle.
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (accept) begin
          if (close_nx) begin
            out_sum_d   = acc_nx;
            out_count_d = cnt_nx;
            out_ovf_d   = ovf_nx;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            state_d     = ST_HOLD;
          end else begin
            acc_d = acc_nx;
            cnt_d = cnt_nx;
            ovf_d = ovf_nx;
          end
        end
      end
      ST_HOLD: begin
        // Result is frozen until the sink takes it; clear has no effect here.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACC;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: one instance with ACC_GUARD=2 for
// sum/handshake/clear/reset scenarios, one with ACC_GUARD=1 for saturation.
module tb_product_accumulator;

  localparam int unsigned PW  = 8;
  localparam int unsigned NT  = 4;
  localparam int unsigned AWA = 2 * PW + 2;
  localparam int unsigned AWS = 2 * PW + 1;
  localparam int unsigned CW  = $clog2(NT + 1);

  logic clk;
  logic rst;

  // Instance A signals
  logic            a_clear, a_in_valid, a_in_last, a_out_ready;
  logic            a_in_ready, a_out_valid, a_out_ovf;
  logic [2*PW-1:0] a_product;
  logic [AWA-1:0]  a_out_sum;
  logic [CW-1:0]   a_out_count;

  // Instance S signals
  logic            s_clear, s_in_valid, s_in_last, s_out_ready;
  logic            s_in_ready, s_out_valid, s_out_ovf;
  logic [2*PW-1:0] s_product;
  logic [AWS-1:0]  s_out_sum;
  logic [CW-1:0]   s_out_count;

  int n_cmp = 0;
  int n_err = 0;

  product_accumulator #(.parallelism(PW), .ACC_GUARD(2), .N_TERMS(NT)) dut_a (
    .clk(clk), .rst(rst), .clear(a_clear),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .product(a_product),
    .in_last(a_in_last), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_count(a_out_count), .out_ovf(a_out_ovf)
  );

  product_accumulator #(.parallelism(PW), .ACC_GUARD(1), .N_TERMS(NT)) dut_s (
    .clk(clk), .rst(rst), .clear(s_clear),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .product(s_product),
    .in_last(s_in_last), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_sum(s_out_sum), .out_count(s_out_count), .out_ovf(s_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One accepted beat on instance A; returns 1 ns after the edge.
  task automatic beat_a(input logic [2*PW-1:0] p, input logic last);
    a_in_valid = 1'b1;
    a_product  = p;
    a_in_last  = last;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
  endtask

  task automatic beat_s(input logic [2*PW-1:0] p, input logic last);
    s_in_valid = 1'b1;
    s_product  = p;
    s_in_last  = last;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    s_in_last  = 1'b0;
  endtask

  task automatic drain_a(input string tag);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    chk({tag, "_drain_valid"}, 32'(a_out_valid), 32'd0);
    chk({tag, "_drain_ready"}, 32'(a_in_ready), 32'd1);
  endtask

  task automatic chk_res_a(input string tag, input logic [31:0] sum,
                           input logic [31:0] cnt, input logic [31:0] ovf);
    chk({tag, "_valid"}, 32'(a_out_valid), 32'd1);
    chk({tag, "_sum"},   32'(a_out_sum),   sum);
    chk({tag, "_count"}, 32'(a_out_count), cnt);
    chk({tag, "_ovf"},   32'(a_out_ovf),   ovf);
    chk({tag, "_inrdy"}, 32'(a_in_ready),  32'd0);
  endtask

  initial begin
    rst = 1'b1;
    a_clear = 0; a_in_valid = 0; a_in_last = 0; a_out_ready = 0; a_product = '0;
    s_clear = 0; s_in_valid = 0; s_in_last = 0; s_out_ready = 0; s_product = '0;
    #3;
    chk("rst_valid", 32'(a_out_valid), 32'd0);
    chk("rst_sum",   32'(a_out_sum),   32'd0);
    chk("rst_count", 32'(a_out_count), 32'd0);
    chk("rst_ovf",   32'(a_out_ovf),   32'd0);
    chk("rst_ready", 32'(a_in_ready),  32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic sum: 4 x 0x121 = 0x484
    beat_a(16'h0121, 1'b0);
    beat_a(16'h0121, 1'b0);
    beat_a(16'h0121, 1'b0);
    chk("basic_pre_valid", 32'(a_out_valid), 32'd0);
    beat_a(16'h0121, 1'b0);
    chk_res_a("basic", 32'h484, 32'd4, 32'd0);

    // Backpressure: 5 cycles out_ready=0 with products offered
    a_in_valid = 1'b1;
    a_product  = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_inrdy", 32'(a_in_ready), 32'd0);
      @(posedge clk); #1;
      chk("bp_valid", 32'(a_out_valid), 32'd1);
      chk("bp_sum",   32'(a_out_sum),   32'h484);
    end
    a_in_valid = 1'b0;
    drain_a("basic");
    chk("bubble_valid", 32'(a_out_valid), 32'd0);

    // Early close: 0x121 + 0x121(last) = 578, fresh from zero
    beat_a(16'h0121, 1'b0);
    beat_a(16'h0121, 1'b1);
    chk_res_a("early", 32'd578, 32'd2, 32'd0);
    a_clear = 1'b1;  // ignored while holding
    @(posedge clk); #1;
    a_clear = 1'b0;
    chk_res_a("hold_clear", 32'd578, 32'd2, 32'd0);
    drain_a("early");

    // Clear: partial sum discarded, the clear-cycle beat not taken
    beat_a(16'h0121, 1'b0);
    beat_a(16'h0121, 1'b0);
    a_clear    = 1'b1;
    a_in_valid = 1'b1;
    a_product  = 16'h0121;
    #1;
    chk("clr_inrdy", 32'(a_in_ready), 32'd0);
    @(posedge clk); #1;
    a_clear    = 1'b0;
    a_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) beat_a(16'h0001, 1'b0);
    chk_res_a("clear", 32'd4, 32'd4, 32'd0);
    drain_a("clear");

    // last on the N_TERMS-th beat: single result
    for (int i = 0; i < 3; i++) beat_a(16'h0002, 1'b0);
    beat_a(16'h0002, 1'b1);
    chk_res_a("lastn", 32'd8, 32'd4, 32'd0);
    drain_a("lastn");
    @(posedge clk); #1;
    chk("lastn_nodouble", 32'(a_out_valid), 32'd0);

    // Zero products still count
    beat_a(16'h0000, 1'b0);
    beat_a(16'h0000, 1'b1);
    chk_res_a("zero", 32'd0, 32'd2, 32'd0);
    drain_a("zero");

    // Reset with 3 beats pending
    for (int i = 0; i < 3; i++) beat_a(16'h0121, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rstacc_valid", 32'(a_out_valid), 32'd0);
    chk("rstacc_ready", 32'(a_in_ready),  32'd1);
    chk("rstacc_sum",   32'(a_out_sum),   32'd0);
    chk("rstacc_count", 32'(a_out_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) beat_a(16'h0121, 1'b0);
    chk_res_a("postrst", 32'h484, 32'd4, 32'd0);

    // Reset while holding a result
    #2;
    rst = 1'b1;
    #1;
    chk("rsthold_valid", 32'(a_out_valid), 32'd0);
    chk("rsthold_ready", 32'(a_in_ready),  32'd1);
    chk("rsthold_sum",   32'(a_out_sum),   32'd0);
    chk("rsthold_count", 32'(a_out_count), 32'd0);
    chk("rsthold_ovf",   32'(a_out_ovf),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    beat_a(16'h0005, 1'b1);
    chk_res_a("rsthold_after", 32'd5, 32'd1, 32'd0);
    drain_a("rsthold_after");

    // Saturation on the 17-bit accumulator: 3 x 0xFE01 overflows
    for (int i = 0; i < 3; i++) beat_s(16'hFE01, 1'b0);
    chk("sat_pre_valid", 32'(s_out_valid), 32'd0);
    beat_s(16'hFE01, 1'b0);
    chk("sat_valid", 32'(s_out_valid), 32'd1);
    chk("sat_sum",   32'(s_out_sum),   32'h1FFFF);
    chk("sat_count", 32'(s_out_count), 32'd4);
    chk("sat_ovf",   32'(s_out_ovf),   32'd1);
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    chk("sat_drain", 32'(s_out_valid), 32'd0);
    beat_s(16'h0001, 1'b0);
    beat_s(16'h0001, 1'b1);
    chk("sat_next_valid", 32'(s_out_valid), 32'd1);
    chk("sat_next_sum",   32'(s_out_sum),   32'd2);
    chk("sat_next_count", 32'(s_out_count), 32'd2);
    chk("sat_next_ovf",   32'(s_out_ovf),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
